gc_evaluator: RTL and testbench

GC_EVALUATOR -- requirements
Module: gc_evaluator

---
 rtl/gc_evaluator.sv | 134 +++++++++++++
 tb/tb_gc_evaluator.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_evaluator.sv
// gc_evaluator: garbled-circuit gate evaluator (free-XOR gates plus two-hash half-gate AND).
// Defining GC_EVAL_STATS_EN enables the AND/free gate accept counters.
module gc_evaluator #(
  parameter int S = 20,
  parameter int K = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gate_valid,
  output logic         gate_ready,
  input  logic [S-1:0] gate_gid,
  input  logic         gate_free,
  input  logic [K-1:0] in0_label,
  input  logic [K-1:0] in1_label,
  input  logic [K-1:0] gt0,
  input  logic [K-1:0] gt1,
  output logic         hash_req_valid,
  output logic [K-1:0] hash_req_label,
  output logic [S-1:0] hash_req_tweak,
  input  logic         hash_rsp_valid,
  input  logic [K-1:0] hash_rsp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [S-1:0] out_gid,
  output logic [K-1:0] out_label,
  output logic [S-1:0] and_count,
  output logic [S-1:0] free_count
);
  typedef enum logic [2:0] {IDLE, HASH0, HASH1, WAIT, OUT} state_t;
  state_t       state_q;
  logic         gate_ready_q, req_valid_q, out_valid_q, rsp_cnt_q;
  logic [S-1:0] and_idx_q, req_tweak_q, gid_q, out_gid_q;
  logic [K-1:0] wa_q, wb_q, tg_q, te_q, h0_q, req_label_q, out_label_q;
  logic [K-1:0] and_label_d;
  // Evaluator half-gate combine, applied when the second hash response arrives.
  assign and_label_d = h0_q ^ (wa_q[0] ? tg_q : '0) ^ hash_rsp_data ^ (wb_q[0] ? (te_q ^ wa_q) : '0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      gate_ready_q <= 1'b0;
      req_valid_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      rsp_cnt_q    <= 1'b0;
      and_idx_q    <= '0;
      req_tweak_q  <= '0;
      gid_q        <= '0;
      out_gid_q    <= '0;
      wa_q         <= '0;
      wb_q         <= '0;
      tg_q         <= '0;
      te_q         <= '0;
      h0_q         <= '0;
      req_label_q  <= '0;
      out_label_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          gate_ready_q <= 1'b1;
          if (gate_valid && gate_ready_q) begin
            gate_ready_q <= 1'b0;
            gid_q        <= gate_gid;
            wa_q         <= in0_label;
            wb_q         <= in1_label;
            tg_q         <= gt0;
            te_q         <= gt1;
            rsp_cnt_q    <= 1'b0;
            if (gate_free) begin
              state_q     <= OUT;
              out_valid_q <= 1'b1;
              out_gid_q   <= gate_gid;
              out_label_q <= in0_label ^ in1_label;
            end else begin
              state_q     <= HASH0;
              and_idx_q   <= and_idx_q + 1'b1;
              req_valid_q <= 1'b1;
              req_label_q <= in0_label;
              req_tweak_q <= and_idx_q << 1;
            end
          end
        end
        HASH0, HASH1, WAIT: begin
          state_q     <= (state_q == HASH0) ? HASH1 : WAIT;
          req_valid_q <= (state_q == HASH0);
          req_label_q <= wb_q;
          req_tweak_q <= {req_tweak_q[S-1:1], 1'b1};
          // Responses are strictly in order: the first is H(Wa,j), the second H(Wb,j+1).
          if (hash_rsp_valid) begin
            rsp_cnt_q <= 1'b1;
            h0_q      <= hash_rsp_data;
            if (rsp_cnt_q) begin
              state_q     <= OUT;
              req_valid_q <= 1'b0;
              out_valid_q <= 1'b1;
              out_gid_q   <= gid_q;
              out_label_q <= and_label_d;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            gate_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gate_ready     = gate_ready_q;
  assign hash_req_valid = req_valid_q;
  assign hash_req_label = req_label_q;
  assign hash_req_tweak = req_tweak_q;
  assign out_valid      = out_valid_q;
  assign out_gid        = out_gid_q;
  assign out_label      = out_label_q;
`ifdef GC_EVAL_STATS_EN
  logic [S-1:0] and_count_q, free_count_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      and_count_q  <= '0;
      free_count_q <= '0;
    end else if (state_q == IDLE && gate_ready_q && gate_valid) begin
      if (gate_free) free_count_q <= free_count_q + 1'b1;
      else and_count_q <= and_count_q + 1'b1;
    end
  end
  assign and_count  = and_count_q;
  assign free_count = free_count_q;
`else
  assign and_count  = '0;
  assign free_count = '0;
`endif
endmodule

// File: tb/tb_gc_evaluator.sv
// tb_gc_evaluator: randomized self-checking bench with an in-order hash responder model.
module tb_gc_evaluator;
  localparam int S = 20;
  localparam int K = 128;
`ifdef GC_EVAL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic         clk = 1'b0, rst = 1'b1;
  logic         gate_valid = 1'b0, gate_free = 1'b0, out_ready = 1'b1, hash_rsp_valid = 1'b0;
  logic [S-1:0] gate_gid = '0;
  logic [K-1:0] in0_label = '0, in1_label = '0, gt0 = '0, gt1 = '0, hash_rsp_data = '0;
  logic         gate_ready, hash_req_valid, out_valid;
  logic [K-1:0] hash_req_label, out_label;
  logic [S-1:0] hash_req_tweak, out_gid, and_count, free_count;

  gc_evaluator #(.S(S), .K(K)) dut (
    .clk(clk), .rst(rst), .gate_valid(gate_valid), .gate_ready(gate_ready),
    .gate_gid(gate_gid), .gate_free(gate_free), .in0_label(in0_label), .in1_label(in1_label),
    .gt0(gt0), .gt1(gt1), .hash_req_valid(hash_req_valid), .hash_req_label(hash_req_label),
    .hash_req_tweak(hash_req_tweak), .hash_rsp_valid(hash_rsp_valid), .hash_rsp_data(hash_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_gid(out_gid), .out_label(out_label),
    .and_count(and_count), .free_count(free_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, lat = 1, n_out = 0, n_rsp = 0, m_and = 0, m_free = 0;
  bit fixed_hash = 1'b0, stray = 1'b0;
  longint cyc = 0;
  typedef struct { logic [K-1:0] d; longint due; } rsp_t;
  rsp_t rq[$];
  logic [S-1:0] tw_q[$];

  function automatic logic [K-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for the garbling hash: any deterministic mix of label and tweak will do.
  function automatic logic [K-1:0] h(input logic [K-1:0] l, input logic [S-1:0] t);
    logic [31:0] m;
    m = {12'd0, t} * 32'h9E3779B9 + 32'h1234567;
    if (fixed_hash) return t[0] ? {16{8'h22}} : {16{8'h11}};
    return {l[K-9:0], l[K-1:K-8]} ^ {4{m}};
  endfunction

  function automatic logic [K-1:0] exp_and(input logic [K-1:0] a, b, tg, te, input logic [S-1:0] j);
    return h(a, j) ^ (a[0] ? tg : '0) ^ h(b, S'(j + 1)) ^ (b[0] ? (te ^ a) : '0);
  endfunction

  function automatic logic [S-1:0] exp_cnt(input int n);
    return STATS ? S'(n) : '0;
  endfunction

  always @(posedge clk) if (hash_req_valid) tw_q.push_back(hash_req_tweak);
  always @(posedge clk) if (out_valid && out_ready) n_out++;

  initial forever begin
    rsp_t e;
    @(posedge clk); #1;
    cyc++;
    if (hash_req_valid) begin
      e.d = h(hash_req_label, hash_req_tweak);
      e.due = cyc + lat;
      rq.push_back(e);
    end
    if (stray) begin
      hash_rsp_valid = 1'b1;
      hash_rsp_data = rnd();
      stray = 1'b0;
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      hash_rsp_valid = 1'b1;
      hash_rsp_data = rq[0].d;
      void'(rq.pop_front());
      n_rsp++;
    end else begin
      hash_rsp_valid = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic accept_gate(input logic [S-1:0] g, input bit fr, input logic [K-1:0] a, b, t0, t1, output bit ok);
    gate_gid = g; gate_free = fr; in0_label = a; in1_label = b; gt0 = t0; gt1 = t1;
    gate_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = gate_ready;
      @(posedge clk); #1;
    end
    gate_valid = 1'b0;
    gate_gid = S'($urandom); in0_label = rnd(); in1_label = rnd(); gt0 = rnd(); gt1 = rnd();
    if (ok) begin
      if (fr) m_free++;
      else m_and++;
    end
  endtask

  task automatic wait_out(output bit ok, output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = out_valid;
  endtask

  task automatic run_gate(input logic [S-1:0] g, input bit fr, input logic [K-1:0] a, b, t0, t1, input int hold,
                          output bit ok, output logic [K-1:0] lab, output logic [S-1:0] gid, output int n);
    bit ok1, ok2;
    out_ready = (hold == 0);
    accept_gate(g, fr, a, b, t0, t1, ok1);
    wait_out(ok2, n);
    lab = out_label;
    gid = out_gid;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({gate_ready, hash_req_valid, hash_req_label, hash_req_tweak, out_valid, out_gid, out_label, and_count, free_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b hreq=%b hlab=%h htw=%h ov=%b gid=%h lab=%h ac=%h fc=%h, want all zero",
               gate_ready, hash_req_valid, hash_req_label, hash_req_tweak, out_valid, out_gid, out_label, and_count, free_count);
    end
    rst = 1'b1;
    m_and = 0; m_free = 0;
    n_checks++;
    if (gate_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_clock: got %b want 0", gate_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (gate_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_clock: got %b want 1", gate_ready); end
  endtask

  task automatic test_and_first();
    logic [K-1:0] a, b, lab;
    logic [S-1:0] gid, j;
    bit ok;
    int n;
    fixed_hash = 1'b1; lat = 3;
    a = rnd() & ~K'(1); b = rnd() & ~K'(1);
    j = S'(2 * m_and);
    run_gate(S'(7), 1'b0, a, b, rnd(), rnd(), 0, ok, lab, gid, n);
    n_checks++;
    if (!ok || lab !== {16{8'h33}} || gid !== S'(7)) begin
      n_fail++; $display("FAIL and_first: ok=%b label=%h gid=%h want label=%h gid=7", ok, lab, gid, {16{8'h33}});
    end
    n_checks++;
    if (tw_q.size() != 2 || tw_q[0] !== j || tw_q[1] !== S'(j + 1)) begin
      n_fail++; $display("FAIL and_first_tweaks: got %0d reqs first=%h want %h,%h", tw_q.size(), tw_q.size() ? tw_q[0] : '0, j, S'(j + 1));
    end
    tw_q.delete();
    fixed_hash = 1'b0;
  endtask

  task automatic test_free();
    logic [K-1:0] lab;
    logic [S-1:0] gid;
    bit ok;
    int n;
    run_gate(S'(9), 1'b1, {16{8'hF0}}, {16{8'h0F}}, rnd(), rnd(), 0, ok, lab, gid, n);
    n_checks++;
    if (!ok || n != 0 || lab !== {16{8'hFF}} || gid !== S'(9)) begin
      n_fail++; $display("FAIL free_gate: ok=%b lat=%0d label=%h gid=%h want lat=0 label=%h gid=9", ok, n, lab, gid, {16{8'hFF}});
    end
    n_checks++;
    if (tw_q.size() != 0) begin n_fail++; $display("FAIL free_no_hash: got %0d requests want 0", tw_q.size()); end
    n_checks++;
    if (and_count !== exp_cnt(m_and) || free_count !== exp_cnt(m_free)) begin
      n_fail++; $display("FAIL stats_free: got and=%0d free=%0d want %0d %0d", and_count, free_count, exp_cnt(m_and), exp_cnt(m_free));
    end
    tw_q.delete();
  endtask

  task automatic test_and_second();
    logic [K-1:0] a, b, tg, te, lab, want;
    logic [S-1:0] gid, j;
    bit ok;
    int n;
    lat = 2;
    a = {rnd() >> 8, 8'h01}; b = rnd() | K'(1);
    tg = {32{4'hA}}; te = {32{4'h5}};
    j = S'(2 * m_and);
    want = exp_and(a, b, tg, te, j);
    run_gate(S'(11), 1'b0, a, b, tg, te, 0, ok, lab, gid, n);
    n_checks++;
    if (!ok || lab !== want || gid !== S'(11)) begin
      n_fail++; $display("FAIL and_second: ok=%b label=%h gid=%h want label=%h gid=11", ok, lab, gid, want);
    end
    n_checks++;
    if (tw_q.size() != 2 || tw_q[0] !== j || tw_q[1] !== S'(j + 1) || j !== S'(2)) begin
      n_fail++; $display("FAIL and_second_tweaks: got %0d reqs first=%h want 2,3", tw_q.size(), tw_q.size() ? tw_q[0] : '0);
    end
    tw_q.delete();
  endtask

  task automatic test_hold();
    logic [K-1:0] a, b, tg, te, want;
    logic [S-1:0] j;
    bit ok1, ok2;
    int n, n0;
    lat = 4;
    a = rnd(); b = rnd(); tg = rnd(); te = rnd();
    j = S'(2 * m_and);
    want = exp_and(a, b, tg, te, j);
    out_ready = 1'b0;
    accept_gate(S'(21), 1'b0, a, b, tg, te, ok1);
    wait_out(ok2, n);
    n0 = n_out;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (!ok1 || !ok2 || out_valid !== 1'b1 || out_label !== want || out_gid !== S'(21) || gate_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d: ov=%b label=%h gid=%h ready=%b want ov=1 label=%h gid=15 ready=0",
                           i, out_valid, out_label, out_gid, gate_ready, want);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || n_out - n0 != 1 || gate_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: ov=%b outputs=%0d ready=%b want ov=0 outputs=1 ready=1", out_valid, n_out - n0, gate_ready);
    end
    tw_q.delete();
  endtask

  task automatic test_latency();
    logic [K-1:0] a, b, tg, te, l1, l20, want;
    logic [S-1:0] gid;
    bit ok1, ok2;
    int n;
    fixed_hash = 1'b1;
    a = rnd(); b = rnd(); tg = rnd(); te = rnd();
    want = exp_and(a, b, tg, te, S'(2 * m_and));
    lat = 1;
    run_gate(S'(31), 1'b0, a, b, tg, te, 0, ok1, l1, gid, n);
    lat = 20;
    run_gate(S'(32), 1'b0, a, b, tg, te, 0, ok2, l20, gid, n);
    n_checks++;
    if (!ok1 || l1 !== want) begin n_fail++; $display("FAIL latency1: ok=%b label=%h want %h", ok1, l1, want); end
    n_checks++;
    if (!ok2 || l20 !== l1) begin n_fail++; $display("FAIL latency20: ok=%b label=%h want %h", ok2, l20, l1); end
    fixed_hash = 1'b0;
    tw_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [K-1:0] a, b, tg, te, lab, want;
    logic [S-1:0] gid;
    bit ok;
    int n, r0;
    lat = 20;
    r0 = n_rsp;
    accept_gate(S'(41), 1'b0, rnd(), rnd(), rnd(), rnd(), ok);
    n = 0;
    while (n_rsp == r0 && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (!ok || n >= 100 || {gate_ready, hash_req_valid, hash_req_label, hash_req_tweak, out_valid, out_gid, out_label, and_count, free_count} !== '0) begin
      n_fail++; $display("FAIL reset_mid: ok=%b wait=%0d ready=%b hreq=%b ov=%b lab=%h ac=%h fc=%h want all zero",
                         ok, n, gate_ready, hash_req_valid, out_valid, out_label, and_count, free_count);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    m_and = 0; m_free = 0;
    stray = 1'b1;
    n = 0;
    while ((rq.size() > 0 || stray) && n < 100) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    tw_q.delete();
    n_checks++;
    if (gate_ready !== 1'b1 || out_valid !== 1'b0 || hash_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL stray_ignored: ready=%b ov=%b hreq=%b want 1 0 0", gate_ready, out_valid, hash_req_valid);
    end
    lat = 3;
    a = rnd(); b = rnd(); tg = rnd(); te = rnd();
    want = exp_and(a, b, tg, te, S'(0));
    run_gate(S'(42), 1'b0, a, b, tg, te, 0, ok, lab, gid, n);
    n_checks++;
    if (!ok || lab !== want || tw_q.size() != 2 || tw_q[0] !== S'(0) || tw_q[1] !== S'(1)) begin
      n_fail++; $display("FAIL after_reset_and: ok=%b label=%h reqs=%0d want label=%h tweaks 0,1", ok, lab, tw_q.size(), want);
    end
    tw_q.delete();
  endtask

  task automatic test_random();
    logic [K-1:0] a, b, tg, te, lab, want;
    logic [S-1:0] gid, g, j;
    bit ok, fr;
    int n, n0;
    n0 = n_out;
    for (int i = 0; i < 30; i++) begin
      fr = ($urandom_range(0, 2) == 0);
      lat = $urandom_range(1, 6);
      a = rnd(); b = rnd(); tg = rnd(); te = rnd(); g = S'($urandom);
      j = S'(2 * m_and);
      want = fr ? (a ^ b) : exp_and(a, b, tg, te, j);
      run_gate(g, fr, a, b, tg, te, $urandom_range(0, 2), ok, lab, gid, n);
      n_checks++;
      if (!ok || lab !== want || gid !== g) begin
        n_fail++; $display("FAIL random%0d: free=%b ok=%b label=%h gid=%h want label=%h gid=%h", i, fr, ok, lab, gid, want, g);
      end
      n_checks++;
      if (fr ? (tw_q.size() != 0) : (tw_q.size() != 2 || tw_q[0] !== j || tw_q[1] !== S'(j + 1))) begin
        n_fail++; $display("FAIL random_tweaks%0d: got %0d reqs want %0d starting %h", i, tw_q.size(), fr ? 0 : 2, j);
      end
      tw_q.delete();
    end
    n_checks++;
    if (n_out - n0 != 30) begin n_fail++; $display("FAIL random_count: got %0d outputs want 30", n_out - n0); end
    n_checks++;
    if (and_count !== exp_cnt(m_and) || free_count !== exp_cnt(m_free)) begin
      n_fail++; $display("FAIL stats_random: got and=%0d free=%0d want %0d %0d", and_count, free_count, exp_cnt(m_and), exp_cnt(m_free));
    end
  endtask

  initial begin
    test_reset();
    test_and_first();
    test_free();
    test_and_second();
    test_hold();
    test_latency();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
